// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Pure declarations; no latency, no backpressure.
package ssd_pkg;

  localparam int WIDTH = 16;

  localparam int REQ_ALARM_SET = 0;
  localparam int REQ_SNOOZE    = 1;
  localparam int REQ_TIME      = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

endpackage

// File: rtl/ssd_tick_gen.sv
// One-cycle strobe every DIV cycles, free-running from reset; registered output.
// No backpressure: the strobe is never stalled.
module ssd_tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ssd_display_arbiter.sv
// Fixed-priority display-word arbiter with minimum dwell and per-requester blink.
// All outputs registered, 1 clk from req/data sample; no backpressure on requesters.
module ssd_display_arbiter #(
  parameter int NREQ     = 3,
  parameter int WIDTH    = ssd_pkg::WIDTH,
  parameter int CLK_HZ   = 100_000_000,
  parameter int DWELL_MS = 500,
  parameter int BLINK_MS = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic [NREQ-1:0]       blink_en,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      disp_data,
  output logic                  disp_blank
);

  import ssd_pkg::*;

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (DWELL_MS > 0) ? $clog2(DWELL_MS + 1) : 1;
  localparam int BW = $clog2(BLINK_MS + 1);

  logic tick;

  ssd_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .tick_o (tick)
  );

  state_e            state_q, state_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              blank_q, blank_d;
  logic [IW-1:0]     low_idx;
  logic              any_req;
  logic              change;

  always_comb begin
    any_req = |req;
    low_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) low_idx = IW'(i);
    end

    state_d = state_q;
    gidx_d  = gidx_q;
    change  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANTED;
          gidx_d  = low_idx;
          change  = 1'b1;
        end
      end
      default: begin
        // Losing the current request overrides the dwell hold.
        if (!req[gidx_q]) begin
          change = 1'b1;
          if (any_req) gidx_d = low_idx;
          else         state_d = ST_IDLE;
        end else if ((low_idx < gidx_q) && (dwell_q == '0)) begin
          gidx_d = low_idx;
          change = 1'b1;
        end
      end
    endcase

    dwell_d = dwell_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (change) begin
      dwell_d = DW'(DWELL_MS);
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (dwell_q != '0) dwell_d = dwell_q - 1'b1;
      if (bcnt_q == BW'(BLINK_MS - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    gnt_d   = '0;
    data_d  = '0;
    blank_d = 1'b1;
    if (state_d == ST_GRANTED) begin
      gnt_d[gidx_d] = 1'b1;
      data_d        = data[int'(gidx_d)*WIDTH +: WIDTH];
      blank_d       = blink_en[gidx_d] & phase_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gidx_q  <= '0;
      dwell_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      gnt_q   <= '0;
      data_q  <= '0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      blank_q <= blank_d;
    end
  end

  assign gnt        = gnt_q;
  assign disp_data  = data_q;
  assign disp_blank = blank_q;

endmodule
